rgb_to_yuv_conversion: RTL and testbench

//  Converts a packed RGB888 frame in SRAM into planar YUV 4:2:2 (Y, U, V planes) in the same SRAM.
//  It is the encode-side counterpart of the YUV-to-RGB converter and uses the same SRAM access style:
//  one read-only port and one write-only port.
//  It runs once per start pulse, processing the frame in groups of 4 pixels (2 pairs), and pulses done at the end.

---
 rtl/rgb_to_yuv_conversion.sv | 227 ++++++++++++++++++++++
 tb/tb_rgb_to_yuv_conversion.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_yuv_conversion.sv
// rgb_to_yuv_conversion
//   Converts a packed RGB888 frame held in SRAM into planar YUV 4:2:2
//   (separate Y, U and V planes) in the same SRAM. The frame is processed
//   in groups of 4 pixels (two pairs) at a fixed 12 cycles per group.
//   One start pulse converts one frame and ends with a done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      begin conversion (only looked at while idle)
//   done       one-cycle pulse when the last group has been written
//   busy       high whenever the block is not idle
//   raddr      SRAM read address; rdata returns one cycle later
//   rdata      SRAM read data
//   waddr      SRAM write address
//   wdata      SRAM write data
//   wr_enable  SRAM write strobe
module rgb_to_yuv_conversion #(
    parameter int ADDR_RGB = 115200,
    parameter int ADDR_Y   = 0,
    parameter int ADDR_U   = 38400,
    parameter int ADDR_V   = 57600,
    parameter int W        = 320,
    parameter int H        = 240,
    parameter int DW       = 16,
    parameter int AW       = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int            NGRP   = W * H / 4;
    localparam logic [AW-1:0] LAST_G = AW'(NGRP - 1);
    localparam logic [AW-1:0] A_RGB  = AW'(ADDR_RGB);
    localparam logic [AW-1:0] A_Y    = AW'(ADDR_Y);
    localparam logic [AW-1:0] A_U    = AW'(ADDR_U);
    localparam logic [AW-1:0] A_V    = AW'(ADDR_V);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RDW,
        S_CALC, S_WR0, S_WR1, S_WR2, S_WR3, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        g_q, g_d;
    logic [AW-1:0]        raddr_q, raddr_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [5:0][DW-1:0]   w_q, w_d;      // six source words of the current group
    logic [3:0][7:0]      y_q, y_d;      // Y0..Y3
    logic [1:0][7:0]      u_q, u_d;      // [0]=pair0, [1]=pair1
    logic [1:0][7:0]      v_q, v_d;
    logic [3:0][7:0]      y_c;
    logic [1:0][7:0]      u_c, v_c;
    logic [AW-1:0]        g6;

    function automatic logic signed [19:0] sx(input logic [7:0] c);
        return $signed({12'd0, c});
    endfunction

    function automatic logic [7:0] sat8(input logic signed [19:0] v);
        if (v < 20'sd0)        return 8'd0;
        else if (v > 20'sd255) return 8'hFF;
        else                   return v[7:0];
    endfunction

    // >>> on a signed operand gives the floor shift needed for negative sums.
    function automatic logic [7:0] calc_y(input logic [7:0] r, g, b);
        logic signed [19:0] t;
        t = 20'sd66 * sx(r) + 20'sd129 * sx(g) + 20'sd25 * sx(b) + 20'sd128;
        return sat8((t >>> 8) + 20'sd16);
    endfunction

    function automatic logic [7:0] calc_u(input logic [7:0] r, g, b);
        logic signed [19:0] t;
        t = 20'sd112 * sx(b) - 20'sd38 * sx(r) - 20'sd74 * sx(g) + 20'sd128;
        return sat8((t >>> 8) + 20'sd128);
    endfunction

    function automatic logic [7:0] calc_v(input logic [7:0] r, g, b);
        logic signed [19:0] t;
        t = 20'sd112 * sx(r) - 20'sd94 * sx(g) - 20'sd18 * sx(b) + 20'sd128;
        return sat8((t >>> 8) + 20'sd128);
    endfunction

    function automatic logic [7:0] avg8(input logic [7:0] a, b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    // Pixel math on the captured words. Byte stream per pair is R0 G0 B0 R1 G1 B1.
    always_comb begin
        y_c = '0;
        u_c = '0;
        v_c = '0;
        for (int p = 0; p < 2; p++) begin
            logic [7:0] ra, ga, ba, rb, gb, bb;
            ra = w_q[3*p][15:8];
            ga = w_q[3*p][7:0];
            ba = w_q[3*p+1][15:8];
            rb = w_q[3*p+1][7:0];
            gb = w_q[3*p+2][15:8];
            bb = w_q[3*p+2][7:0];
            y_c[2*p]   = calc_y(ra, ga, ba);
            y_c[2*p+1] = calc_y(rb, gb, bb);
            u_c[p]     = calc_u(avg8(ra, rb), avg8(ga, gb), avg8(ba, bb));
            v_c[p]     = calc_v(avg8(ra, rb), avg8(ga, gb), avg8(ba, bb));
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        w_d     = w_q;
        y_d     = y_q;
        u_d     = u_q;
        v_d     = v_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RD0;
                g_d     = '0;
            end
            S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RDW,
            S_CALC, S_WR0, S_WR1, S_WR2:
                state_d = state_t'(state_q + 4'd1);
            S_WR3: if (g_q == LAST_G) begin
                state_d = S_DONE;
            end else begin
                state_d = S_RD0;
                g_d     = g_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Each word arrives one cycle after its address was issued.
        case (state_q)
            S_RD1: w_d[0] = rdata;
            S_RD2: w_d[1] = rdata;
            S_RD3: w_d[2] = rdata;
            S_RD4: w_d[3] = rdata;
            S_RD5: w_d[4] = rdata;
            S_RDW: w_d[5] = rdata;
            S_CALC: begin
                y_d = y_c;
                u_d = u_c;
                v_d = v_c;
            end
            default: ;
        endcase

        // Address/data registers are loaded for the state being entered so
        // they line up with it, and simply hold everywhere else. y_d/u_d/v_d
        // are used so the CALC->WR0 transition picks up the fresh results.
        g6 = (g_d << 2) + (g_d << 1);
        case (state_d)
            S_RD0: raddr_d = A_RGB + g6;
            S_RD1: raddr_d = A_RGB + g6 + AW'(1);
            S_RD2: raddr_d = A_RGB + g6 + AW'(2);
            S_RD3: raddr_d = A_RGB + g6 + AW'(3);
            S_RD4: raddr_d = A_RGB + g6 + AW'(4);
            S_RD5: raddr_d = A_RGB + g6 + AW'(5);
            S_WR0: begin
                waddr_d = A_Y + (g_d << 1);
                wdata_d = {y_d[0], y_d[1]};
            end
            S_WR1: begin
                waddr_d = A_Y + (g_d << 1) + AW'(1);
                wdata_d = {y_d[2], y_d[3]};
            end
            S_WR2: begin
                waddr_d = A_U + g_d;
                wdata_d = {u_d[0], u_d[1]};
            end
            S_WR3: begin
                waddr_d = A_V + g_d;
                wdata_d = {v_d[0], v_d[1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            w_q     <= '0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            raddr_q <= A_RGB;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            w_q     <= w_d;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign wr_enable = (state_q == S_WR0) || (state_q == S_WR1) ||
                       (state_q == S_WR2) || (state_q == S_WR3);
    assign raddr     = raddr_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_rgb_to_yuv_conversion.sv
// Bench for rgb_to_yuv_conversion. dut_a runs single-group (4x1) frames
// from a vector table plus the start-held / mid-frame reset sequence;
// dut_b runs an 8x4 random frame to cover group stepping. Every SRAM
// write is compared against an expected-write queue filled when the
// source pixels are loaded.
module tb_rgb_to_yuv_conversion;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int ADDR_RGB = 115200;
    localparam int ADDR_Y   = 0;
    localparam int ADDR_U   = 38400;
    localparam int ADDR_V   = 57600;
    localparam int NGA = 1;            // 4x1
    localparam int NGB = 8;            // 8x4

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start_a, start_b;
    logic          done_a, busy_a, wr_a, done_b, busy_b, wr_b;
    logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
    logic [DW-1:0] rdata_a, wdata_a, rdata_b, wdata_b;

    logic [15:0] mem_a [0:(1<<AW)-1];
    logic [15:0] mem_b [0:(1<<AW)-1];

    always @(posedge clk) rdata_a <= mem_a[raddr_a];
    always @(posedge clk) rdata_b <= mem_b[raddr_b];

    rgb_to_yuv_conversion #(.W(4), .H(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a), .busy(busy_a),
        .raddr(raddr_a), .rdata(rdata_a), .waddr(waddr_a), .wdata(wdata_a),
        .wr_enable(wr_a));

    rgb_to_yuv_conversion #(.W(8), .H(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b), .busy(busy_b),
        .raddr(raddr_b), .rdata(rdata_b), .waddr(waddr_b), .wdata(wdata_b),
        .wr_enable(wr_b));

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [95:0] px;     // 4 pixels {R,G,B}, pixel 0 in the top bits
        logic [15:0] y01, y23, u, v;
    } vec_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction
    function automatic int fy(input int r, input int g, input int b);
        return sat(((66*r + 129*g + 25*b + 128) >>> 8) + 16);
    endfunction
    function automatic int fu(input int r, input int g, input int b);
        return sat(((-38*r - 74*g + 112*b + 128) >>> 8) + 128);
    endfunction
    function automatic int fv(input int r, input int g, input int b);
        return sat(((112*r - 94*g - 18*b + 128) >>> 8) + 128);
    endfunction

    // Returns {Y01, Y23, U, V} words.
    function automatic logic [63:0] model(input logic [95:0] px);
        int r[4], g[4], b[4], y[4], u[2], v[2];
        for (int i = 0; i < 4; i++) begin
            r[i] = int'(px[95-24*i -: 8]);
            g[i] = int'(px[87-24*i -: 8]);
            b[i] = int'(px[79-24*i -: 8]);
            y[i] = fy(r[i], g[i], b[i]);
        end
        for (int p = 0; p < 2; p++) begin
            u[p] = fu((r[2*p]+r[2*p+1]+1)/2, (g[2*p]+g[2*p+1]+1)/2, (b[2*p]+b[2*p+1]+1)/2);
            v[p] = fv((r[2*p]+r[2*p+1]+1)/2, (g[2*p]+g[2*p+1]+1)/2, (b[2*p]+b[2*p+1]+1)/2);
        end
        return {8'(y[0]), 8'(y[1]), 8'(y[2]), 8'(y[3]),
                8'(u[0]), 8'(u[1]), 8'(v[0]), 8'(v[1])};
    endfunction

    // Load one group's source words and push its four expected writes.
    task automatic load_group(input bit sel, input int g, input logic [95:0] px,
                              input logic [15:0] y01, input logic [15:0] y23,
                              input logic [15:0] u, input logic [15:0] v);
        wr_t e[4];
        for (int k = 0; k < 6; k++) begin
            if (sel) mem_b[ADDR_RGB + 6*g + k] = px[95-16*k -: 16];
            else     mem_a[ADDR_RGB + 6*g + k] = px[95-16*k -: 16];
        end
        e[0] = '{addr: 18'(ADDR_Y + 2*g),     data: y01};
        e[1] = '{addr: 18'(ADDR_Y + 2*g + 1), data: y23};
        e[2] = '{addr: 18'(ADDR_U + g),       data: u};
        e[3] = '{addr: 18'(ADDR_V + g),       data: v};
        for (int k = 0; k < 4; k++) begin
            if (sel) q_b.push_back(e[k]);
            else     q_a.push_back(e[k]);
        end
    endtask

    // ---------------- write monitors ----------------
    always @(negedge clk) begin
        wr_t e;
        if (wr_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_a_unexpected: addr %0h data %0h, none expected", waddr_a, wdata_a);
            end else begin
                e = q_a.pop_front();
                check("wr_a_addr", 32'(waddr_a), 32'(e.addr));
                check("wr_a_data", 32'(wdata_a), 32'(e.data));
            end
        end
        if (int'(raddr_a) < ADDR_RGB || int'(raddr_a) >= ADDR_RGB + 6*NGA) begin
            total++; bad++;
            $display("FAIL raddr_a_range: got %0h", raddr_a);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (wr_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_b_unexpected: addr %0h data %0h, none expected", waddr_b, wdata_b);
            end else begin
                e = q_b.pop_front();
                check("wr_b_addr", 32'(waddr_b), 32'(e.addr));
                check("wr_b_data", 32'(wdata_b), 32'(e.data));
            end
        end
        if (int'(raddr_b) < ADDR_RGB || int'(raddr_b) >= ADDR_RGB + 6*NGB) begin
            total++; bad++;
            $display("FAIL raddr_b_range: got %0h", raddr_b);
        end
    end

    // Start a frame and check the done cycle (start accepted = cycle 0).
    task automatic run(input bit sel, input bit hold, input int exp_cyc);
        int n;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        n = 1;
        check("busy_running", 32'(sel ? busy_b : busy_a), 32'd1);
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        while (!(sel ? done_b : done_a) && n < exp_cyc + 50) begin
            @(negedge clk);
            n++;
        end
        check("done_cycle", 32'(n), 32'(exp_cyc));
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'(sel ? done_b : done_a), 32'd0);
        check("idle_after_done", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        logic [63:0] m;
        logic [95:0] px;

        tbl[0] = '{96'h0, 16'h1010, 16'h1010, 16'h8080, 16'h8080};
        tbl[1] = '{{4{24'hFFFFFF}}, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080};
        tbl[2] = '{{4{24'hFF0000}}, 16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0};
        tbl[3] = '{{24'hFF0000, 24'h0, 24'h0, 24'h0}, 16'h5210, 16'h1010, 16'h6D80, 16'hB880};
        tbl[4] = '{{4{24'h0000FF}}, 16'h2929, 16'h2929, 16'hF0F0, 16'h6E6E};
        for (int i = 5; i < 8; i++) begin
            px = {$urandom(), $urandom(), $urandom()};
            m  = model(px);
            tbl[i] = '{px, m[63:48], m[47:32], m[31:16], m[15:0]};
        end

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_wr",    32'(wr_a),    32'd0);
        check("rst_waddr", 32'(waddr_a), 32'd0);
        check("rst_wdata", 32'(wdata_a), 32'd0);
        check("rst_raddr", 32'(raddr_a), 32'(ADDR_RGB));
        check("rst_raddr_b", 32'(raddr_b), 32'(ADDR_RGB));
        reset = 1'b0;

        // Table of single-group frames.
        for (int i = 0; i < 8; i++) begin
            load_group(1'b0, 0, tbl[i].px, tbl[i].y01, tbl[i].y23, tbl[i].u, tbl[i].v);
            run(1'b0, 1'b0, 13);
            check("queue_a_drained", 32'(q_a.size()), 32'd0);
        end
        check("hold_waddr", 32'(waddr_a), 32'(ADDR_V));
        check("hold_wdata", 32'(wdata_a), 32'(tbl[7].v));

        // start held high through a whole run must not disturb it.
        load_group(1'b0, 0, tbl[3].px, tbl[3].y01, tbl[3].y23, tbl[3].u, tbl[3].v);
        run(1'b0, 1'b1, 13);
        check("queue_a_hold_run", 32'(q_a.size()), 32'd0);

        // Reset in WR1 with start held high.
        load_group(1'b0, 0, tbl[6].px, tbl[6].y01, tbl[6].y23, tbl[6].u, tbl[6].v);
        @(negedge clk);
        start_a = 1'b1;
        repeat (10) @(negedge clk);        // cycle 10 = WR1
        check("wr1_strobe", 32'(wr_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_wr",   32'(wr_a),   32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_partial_writes", 32'(q_a.size()), 32'd2);
        q_a.delete();
        reset = 1'b0;
        start_a = 1'b0;
        load_group(1'b0, 0, tbl[2].px, tbl[2].y01, tbl[2].y23, tbl[2].u, tbl[2].v);
        run(1'b0, 1'b0, 13);
        check("queue_a_restart", 32'(q_a.size()), 32'd0);

        // Multi-group random frame on dut_b.
        for (int g = 0; g < NGB; g++) begin
            px = {$urandom(), $urandom(), $urandom()};
            m  = model(px);
            load_group(1'b1, g, px, m[63:48], m[47:32], m[31:16], m[15:0]);
        end
        run(1'b1, 1'b0, 12*NGB + 1);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        check("hold_waddr_b", 32'(waddr_b), 32'(ADDR_V + NGB - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
